ip_tile_alu_result_fifo: RTL

Downstream capture stage for the 8-bit ALU tile: it samples the ALU's 32-bit result word (flags in [31:28], result in [7:0]) into an 8-entry FIFO and presents the head entry to the host. The host pops entries through `csr_in`, and reads occupancy, sticky error bits and accumulated ALU flags on `csr_out`. It sits between the ALU tile's `data_reg_c` and the host register file. It lets a burst of ALU operations run back-to-back without the host reading each result in the same cycle.

---
 rtl/ip_tile_alu_result_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ip_tile_alu_result_fifo.sv
// Capture FIFO for the ALU tile result word.
// Samples {flags, result} into a small FIFO, presents the head entry to the host,
// and reports occupancy, sticky errors and accumulated ALU flags on csr_out.
module ip_tile_alu_result_fifo #(
    parameter int unsigned REG_WIDTH     = 32,
    parameter int unsigned CSR_IN_WIDTH  = 16,
    parameter int unsigned CSR_OUT_WIDTH = 16,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [REG_WIDTH-1:0]     data_reg_c,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_in_re,
    output logic                     csr_out_we
);

    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);
    localparam logic [2:0] PTR_LAST  = 3'(DEPTH - 1);

    // Storage: {flags[3:0], result[7:0]}; not reset, visibility gated by count
    logic [11:0] mem_q [DEPTH];

    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        pop_q;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic [3:0]  flag_acc_q, flag_acc_d;
    logic [3:0]  zdiv_cnt_q, zdiv_cnt_d;
    logic        re_q, we_q;

    logic        clear, push_req, pop_req, push_acc, pop_acc;
    logic [11:0] entry;
    logic [11:0] head;
    logic [15:0] status_q, status_d;

    logic unused_bits;
    assign unused_bits = ^{csr_in[CSR_IN_WIDTH-1:3], data_reg_a[27:8], data_reg_b[REG_WIDTH-1:1]};

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == PTR_LAST) ? 3'd0 : p + 3'd1;
    endfunction

    function automatic logic [15:0] pack_status(input logic [3:0] cnt, input logic ovf,
                                                input logic udf, input logic [3:0] flags,
                                                input logic [3:0] zdiv);
        return {zdiv, flags, udf, ovf, (cnt == DEPTH_CNT), (cnt == 4'd0), cnt};
    endfunction

    assign clear    = csr_in[1];
    assign push_req = csr_in[2] & data_reg_b[0];
    // Pop is edge-detected so a held request pops only once
    assign pop_req  = csr_in[0] & ~pop_q;
    assign entry    = {data_reg_a[31:28], data_reg_a[7:0]};

    // A full FIFO can still take a push when a pop frees a slot in the same cycle
    assign pop_acc  = ~clear & pop_req & (count_q != 4'd0);
    assign push_acc = ~clear & push_req & ((count_q < DEPTH_CNT) | pop_acc);

    // Next-state for pointers, occupancy, sticky bits and flag statistics
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        flag_acc_d = flag_acc_q;
        zdiv_cnt_d = zdiv_cnt_q;
        if (clear) begin
            rd_ptr_d   = 3'd0;
            wr_ptr_d   = 3'd0;
            count_d    = 4'd0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
            flag_acc_d = 4'd0;
            zdiv_cnt_d = 4'd0;
        end else begin
            if (push_acc) begin
                wr_ptr_d   = ptr_inc(wr_ptr_q);
                flag_acc_d = flag_acc_q | entry[11:8];
                if (entry[9] && (zdiv_cnt_q != 4'hF)) begin
                    zdiv_cnt_d = zdiv_cnt_q + 4'd1;
                end
            end
            if (pop_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_req && !push_acc) begin
                ovf_d = 1'b1;
            end
            if (pop_req && (count_q == 4'd0)) begin
                udf_d = 1'b1;
            end
            count_d = count_q + 4'(push_acc) - 4'(pop_acc);
        end
    end

    assign status_q = pack_status(count_q, ovf_q, udf_q, flag_acc_q, zdiv_cnt_q);
    assign status_d = pack_status(count_d, ovf_d, udf_d, flag_acc_d, zdiv_cnt_d);

    // State and event-pulse registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr_q   <= 3'd0;
            wr_ptr_q   <= 3'd0;
            count_q    <= 4'd0;
            pop_q      <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            flag_acc_q <= 4'd0;
            zdiv_cnt_q <= 4'd0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pop_q      <= csr_in[0];
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            flag_acc_q <= flag_acc_d;
            zdiv_cnt_q <= zdiv_cnt_d;
            re_q       <= pop_acc;
            // Clear always announces itself, even if status was already idle
            we_q       <= clear | (status_d != status_q);
        end
    end

    // Entry storage write
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign data_reg_c = (count_q != 4'd0) ?
                        {head[11:8], {(REG_WIDTH - 12){1'b0}}, head[7:0]} : '0;
    assign csr_out    = CSR_OUT_WIDTH'(status_q);
    assign csr_in_re  = re_q;
    assign csr_out_we = we_q;

endmodule
